instr_fetch_reg: RTL and testbench



---
 rtl/instr_fetch_reg.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_reg.sv
// Instruction fetch register stage: issues a req/ack read at pc_reg, latches the returned word
// with its PC and presents registered decode fields. Optional timeout: define IFR_TIMEOUT_EN.
module instr_fetch_reg #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSN       = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_reg,
  input  logic        fetch_start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_reg,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic        fetch_done,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

`ifdef IFR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
`ifdef IFR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          valid_d = 1'b0;
          if (pc_reg[1:0] == 2'b00) begin
            addr_d  = pc_reg;
            req_d   = 1'b1;
            state_d = S_REQ;
`ifdef IFR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Misaligned PC faults without touching memory.
            ir_d    = NOP_INSN;
            ipc_d   = pc_reg;
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
`ifdef IFR_TIMEOUT_EN
        // Expiry is checked one count early so req stays high for exactly TIMEOUT_CYCLES.
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          ir_d    = NOP_INSN;
          ipc_d   = addr_q;
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= NOP_INSN;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

`ifdef IFR_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_reg   = ir_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign fetch_done  = done_q;
  assign fetch_fault = fault_q;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed, table-driven bench for instr_fetch_reg plus hand-written multi-cycle corner cases.
module tb_instr_fetch_reg;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_reg = '0;
  logic        fetch_start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_reg, instr_pc;
  logic        instr_valid;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        fetch_done, fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_reg #(
    .TIMEOUT_CYCLES(4),
    .NOP_INSN      (Nop)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_reg     (pc_reg),
    .fetch_start(fetch_start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_reg  (instr_reg),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .rd         (rd),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct7     (funct7),
    .fetch_done (fetch_done),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          delay;   // idle REQ cycles before ack
    logic [31:0] rdata;
    logic        fault;   // expect misaligned fault
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    pc_reg      = v.pc;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    if (v.fault) begin
      check("mis_req", 32'(imem_req), 32'd0);
      check("mis_fault", 32'(fetch_fault), 32'd1);
      check("mis_done", 32'(fetch_done), 32'd0);
      check("mis_ir", instr_reg, Nop);
      check("mis_pc", instr_pc, v.pc);
      check("mis_valid", 32'(instr_valid), 32'd0);
      step();
      check("mis_fault_end", 32'(fetch_fault), 32'd0);
      check("mis_req2", 32'(imem_req), 32'd0);
    end else begin
      check("req_up", 32'(imem_req), 32'd1);
      check("addr", imem_addr, v.pc);
      check("valid_clr", 32'(instr_valid), 32'd0);
      for (int i = 0; i < v.delay; i++) begin
        step();
        check("req_wait", 32'(imem_req), 32'd1);
        check("done_wait", 32'(fetch_done), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEADBEEF;
      check("req_down", 32'(imem_req), 32'd0);
      check("done", 32'(fetch_done), 32'd1);
      check("ir", instr_reg, v.rdata);
      check("ipc", instr_pc, v.pc);
      check("valid", 32'(instr_valid), 32'd1);
      check("opcode", 32'(opcode), 32'(v.rdata[6:0]));
      check("rd", 32'(rd), 32'(v.rdata[11:7]));
      check("funct3", 32'(funct3), 32'(v.rdata[14:12]));
      check("rs1", 32'(rs1), 32'(v.rdata[19:15]));
      check("rs2", 32'(rs2), 32'(v.rdata[24:20]));
      check("funct7", 32'(funct7), 32'(v.rdata[31:25]));
      step();
      check("done_end", 32'(fetch_done), 32'd0);
      check("ir_hold", instr_reg, v.rdata);
      check("valid_hold", 32'(instr_valid), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{pc: 32'h00002230, delay: 2, rdata: 32'h00A28293, fault: 1'b0};
    vecs[1] = '{pc: 32'h00002231, delay: 0, rdata: 32'h0,        fault: 1'b1};
    vecs[2] = '{pc: 32'h00001000, delay: 0, rdata: 32'h002081B3, fault: 1'b0};
    vecs[3] = '{pc: 32'h00002232, delay: 0, rdata: 32'h0,        fault: 1'b1};
    vecs[4] = '{pc: 32'hFFFFFFFC, delay: 1, rdata: 32'hFE010113, fault: 1'b0};
    vecs[5] = '{pc: 32'h00002233, delay: 0, rdata: 32'h0,        fault: 1'b1};

    // Reset state
    step();
    step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_ir", instr_reg, Nop);
    check("rst_opcode", 32'(opcode), 32'h13);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_funct7", 32'(funct7), 32'd0);
    check("rst_ipc", instr_pc, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hand-decoded fields of the first vector's word.
    run_vec(vecs[0]);
    check("v0_rd", 32'(rd), 32'd5);
    check("v0_rs1", 32'(rs1), 32'd5);
    check("v0_funct3", 32'(funct3), 32'd0);

    // fetch_start held high, pc_reg changes mid-request
    pc_reg      = 32'h00003000;
    fetch_start = 1'b1;
    step();
    pc_reg = 32'h00005237;
    step();
    check("hold_addr", imem_addr, 32'h00003000);
    check("hold_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00100093;
    step();
    imem_ack = 1'b0;
    check("hold_done", 32'(fetch_done), 32'd1);
    check("hold_ipc", instr_pc, 32'h00003000);
    step();
    check("hold_done_end", 32'(fetch_done), 32'd0);
    check("hold_no_req", 32'(imem_req), 32'd0);
    fetch_start = 1'b0;
    step();
    check("hold_no_req2", 32'(imem_req), 32'd0);
    check("hold_ir", instr_reg, 32'h00100093);

    // Reset while a request is outstanding, then a late ack
    pc_reg      = 32'h00004000;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("mr_req", 32'(imem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_async_req", 32'(imem_req), 32'd0);
    check("mr_async_valid", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h12345678;
    step();
    reset = 1'b0;
    step();
    imem_ack = 1'b0;
    check("mr_done", 32'(fetch_done), 32'd0);
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_ir", instr_reg, Nop);
    check("mr_ipc", instr_pc, 32'd0);
    check("mr_addr", imem_addr, 32'd0);
    check("mr_req2", 32'(imem_req), 32'd0);
    step();

`ifdef IFR_TIMEOUT_EN
    // No ack: request held for exactly 4 cycles, then one fault pulse
    pc_reg      = 32'h00006000;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("to_req1", 32'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_req", 32'(imem_req), 32'd1);
      check("to_nofault", 32'(fetch_fault), 32'd0);
    end
    step();
    check("to_req_down", 32'(imem_req), 32'd0);
    check("to_fault", 32'(fetch_fault), 32'd1);
    check("to_ir", instr_reg, Nop);
    check("to_valid", 32'(instr_valid), 32'd0);
    step();
    check("to_fault_end", 32'(fetch_fault), 32'd0);
    check("to_done", 32'(fetch_done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
